// File: rtl/aes_round_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_seq_if
//  Description : Control bundle between the block-level controller and the
//                AES round sequencer.
//                master = controller side (drives start/key_len/en[/dec])
//                slave  = sequencer side  (drives cs/rnd/last/busy/done/err)
//  Signals     : start    request a new block (sampled only in IDLE)
//                key_len  00=128 01=192 10=256 11=reserved
//                dec      inverse-cipher select (only with AES_DEC_EN)
//                en       advance enable while busy
//                cs       current operation code
//                rnd      current round index (CW bits)
//                last     final round in progress
//                busy     cs != IDLE
//                done     cs == FIN
//                err      one-cycle pulse on start with reserved key_len
//  Options     : AES_DEC_EN adds the dec select
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_seq_if #(
   parameter int CW = 4
);
   logic          start;
   logic [1:0]    key_len;
`ifdef AES_DEC_EN
   logic          dec;
`endif
   logic          en;
   logic [2:0]    cs;
   logic [CW-1:0] rnd;
   logic          last;
   logic          busy;
   logic          done;
   logic          err;

`ifdef AES_DEC_EN
   modport master (output start, key_len, dec, en,
                   input  cs, rnd, last, busy, done, err);
   modport slave  (input  start, key_len, dec, en,
                   output cs, rnd, last, busy, done, err);
`else
   modport master (output start, key_len, en,
                   input  cs, rnd, last, busy, done, err);
   modport slave  (input  start, key_len, en,
                   output cs, rnd, last, busy, done, err);
`endif
endinterface
`default_nettype wire

// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_seq
//  Description : Iterative AES round sequencer. Emits one operation code per
//                cycle (ADD/EXP/SUB/SHI/MIX, then FIN) plus the round index
//                for AES-128/192/256, chosen per block when start is taken.
//  Ports       : clk   rising-edge clock
//                res   asynchronous active-low reset
//                bus   aes_round_seq_if.slave (start/key_len/en[/dec] in,
//                      cs/rnd/last/busy/done/err out)
//  Parameters  : CW     round counter width, 2^CW > max(NR128,NR192,NR256)
//                NR128  rounds for key_len=00
//                NR192  rounds for key_len=01
//                NR256  rounds for key_len=10
//  Options     : AES_DEC_EN enables the inverse-cipher sequence (dec=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_seq #(
   parameter int CW    = 4,
   parameter int NR128 = 10,
   parameter int NR192 = 12,
   parameter int NR256 = 14
) (
   input  logic              clk,
   input  logic              res,
   aes_round_seq_if.slave    bus
);

   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_ADD  = 3'b001;
   localparam logic [2:0] S_SUB  = 3'b010;
   localparam logic [2:0] S_EXP  = 3'b011;
   localparam logic [2:0] S_SHI  = 3'b100;
   localparam logic [2:0] S_MIX  = 3'b101;
   localparam logic [2:0] S_FIN  = 3'b111;

   localparam logic [CW-1:0] C_NR128 = CW'(NR128);
   localparam logic [CW-1:0] C_NR192 = CW'(NR192);
   localparam logic [CW-1:0] C_NR256 = CW'(NR256);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   logic [2:0]    r_cs,  w_cs_nxt;
   logic [CW-1:0] r_rnd, w_rnd_nxt;
   logic [CW-1:0] r_nr,  w_nr_nxt;
   logic          r_err, w_err_nxt;
   logic          r_dec, w_dec_nxt;
   logic [CW-1:0] w_nr_sel;
   logic          w_dec_mode;
   logic          w_dec_in;
   logic [CW-1:0] w_last_rnd;
   logic          w_busy;
   logic          w_done;

`ifdef AES_DEC_EN
   assign w_dec_in   = bus.dec;
   assign w_dec_mode = r_dec;
`else
   // Encrypt-only build: the inverse branches below are constant-folded away.
   assign w_dec_in   = 1'b0;
   assign w_dec_mode = 1'b0;
`endif

   // Round count for the requested key length (reserved code never used).
   always_comb begin
      w_nr_sel = C_NR128;
      case (bus.key_len)
         2'b01:   w_nr_sel = C_NR192;
         2'b10:   w_nr_sel = C_NR256;
         default: w_nr_sel = C_NR128;
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_cs  <= S_IDLE;
         r_rnd <= '0;
         r_nr  <= '0;
         r_err <= 1'b0;
         r_dec <= 1'b0;
      end else begin
         r_cs  <= w_cs_nxt;
         r_rnd <= w_rnd_nxt;
         r_nr  <= w_nr_nxt;
         r_err <= w_err_nxt;
         r_dec <= w_dec_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_cs_nxt  = r_cs;
      w_rnd_nxt = r_rnd;
      w_nr_nxt  = r_nr;
      w_err_nxt = 1'b0;
      w_dec_nxt = r_dec;
      case (r_cs)
         S_IDLE: begin
            // en is deliberately ignored here: acceptance depends on start only.
            if (bus.start) begin
               if (bus.key_len == 2'b11) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_nr_nxt  = w_nr_sel;
                  w_dec_nxt = w_dec_in;
                  w_rnd_nxt = w_dec_in ? w_nr_sel : '0;
                  w_cs_nxt  = S_ADD;
               end
            end
         end
         S_ADD: begin
            if (bus.en) begin
               if (!w_dec_mode) begin
                  if (r_rnd == r_nr) begin
                     w_cs_nxt = S_FIN;
                  end else begin
                     w_rnd_nxt = r_rnd + C_ONE;
                     w_cs_nxt  = S_EXP;
                  end
               end else begin
                  if (r_rnd == '0) begin
                     w_cs_nxt = S_FIN;
                  end else if (r_rnd == r_nr) begin
                     // First inverse round has no InvMixColumns.
                     w_rnd_nxt = r_rnd - C_ONE;
                     w_cs_nxt  = S_SHI;
                  end else begin
                     w_cs_nxt = S_MIX;
                  end
               end
            end
         end
         S_EXP: begin
            if (bus.en) w_cs_nxt = w_dec_mode ? S_ADD : S_SUB;
         end
         S_SUB: begin
            if (bus.en) w_cs_nxt = w_dec_mode ? S_EXP : S_SHI;
         end
         S_SHI: begin
            if (bus.en) begin
               if (w_dec_mode)          w_cs_nxt = S_SUB;
               else if (r_rnd == r_nr)  w_cs_nxt = S_ADD;   // final round skips MIX
               else                     w_cs_nxt = S_MIX;
            end
         end
         S_MIX: begin
            if (bus.en) begin
               if (w_dec_mode) begin
                  w_rnd_nxt = r_rnd - C_ONE;
                  w_cs_nxt  = S_SHI;
               end else begin
                  w_cs_nxt  = S_ADD;
               end
            end
         end
         S_FIN: begin
            if (bus.en) w_cs_nxt = S_IDLE;
         end
         default: begin
            // Unused code 110 recovers to IDLE unconditionally.
            w_cs_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode (registered state only, so glitch-free w.r.t. clk)
   // ------------------------------------------------------------------
   always_comb begin
      w_busy     = (r_cs != S_IDLE);
      w_done     = (r_cs == S_FIN);
      w_last_rnd = w_dec_mode ? '0 : r_nr;
      bus.cs     = r_cs;
      bus.rnd    = r_rnd;
      bus.busy   = w_busy;
      bus.done   = w_done;
      bus.last   = w_busy && !w_done && (r_rnd == w_last_rnd);
      bus.err    = r_err;
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_seq
//  Description : Self-checking bench for aes_round_seq. Stimulus pushes the
//                hand-computed expectation of each block into a queue; a
//                monitor pops it when a block starts and compares latency,
//                round counts and last/done behaviour when the block ends.
//  Options     : AES_DEC_EN adds an inverse-cipher block
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_seq;

   localparam int CW = 4;
   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_ADD  = 3'b001;
   localparam logic [2:0] S_SUB  = 3'b010;
   localparam logic [2:0] S_MIX  = 3'b101;
   localparam logic [2:0] S_FIN  = 3'b111;

   // First six cs codes of a block, 3 bits each, oldest in the MSBs.
   localparam logic [17:0] C_ENC6 = {3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd1};
   localparam logic [17:0] C_DEC6 = {3'd1, 3'd4, 3'd2, 3'd3, 3'd1, 3'd5};

   typedef struct {
      bit          abort;
      int          lat;
      int          fin_rnd;
      int          last_rnd;
      int          n_last;
      int          n_mix;
      int          n_add;
      logic [17:0] first6;
   } exp_t;

   logic clk;
   logic res;
   int   n_tests;
   int   n_fail;
   int   n_decode_bad;
   exp_t sb_q[$];
   int   err_q[$];

   aes_round_seq_if #(.CW(CW)) bus ();

   aes_round_seq #(.CW(CW), .NR128(10), .NR192(12), .NR256(14)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   initial begin : monitor
      exp_t        cur;
      bit          active;
      bit          seen_fin;
      bit          err_prev;
      int          cyc, lat, fin_rnd, n_last, n_mix, n_add, last_bad;
      logic [17:0] trace;
      logic [2:0]  prev_cs;
      logic        w_last;
      active = 0; err_prev = 0; prev_cs = S_IDLE;
      cyc = 0; lat = 0; fin_rnd = 0; n_last = 0; n_mix = 0; n_add = 0;
      last_bad = 0; seen_fin = 0; trace = '0;
      forever begin
         @(negedge clk);
         if (!res) begin
            active = 0; prev_cs = S_IDLE; err_prev = 0;
            continue;
         end
         if (err_prev) chk("err_width", int'(bus.err), 0);
         if (bus.err) begin
            if (err_q.size() == 0) chk("unexpected_err", 1, 0);
            else begin
               void'(err_q.pop_front());
               chk("err_cs_idle", int'({bus.cs, bus.busy}), 0);
            end
         end
         err_prev = bus.err;
         if ((bus.busy !== (bus.cs != S_IDLE)) || (bus.done !== (bus.cs == S_FIN)))
            n_decode_bad++;

         if (!active && bus.cs != S_IDLE && prev_cs == S_IDLE) begin
            if (sb_q.size() == 0) chk("unexpected_block", 1, 0);
            else begin
               cur = sb_q.pop_front();
               active = 1; cyc = 0; seen_fin = 0; lat = -1; fin_rnd = -1;
               n_last = 0; n_mix = 0; n_add = 0; last_bad = 0; trace = '0;
            end
         end else if (active) begin
            cyc++;
         end

         if (active) begin
            if (cyc < 6) trace[17-3*cyc -: 3] = bus.cs;
            if (bus.cs == S_ADD) n_add++;
            if (bus.cs == S_MIX) n_mix++;
            if (bus.last) n_last++;
            w_last = bus.busy && !bus.done && (int'(bus.rnd) == cur.last_rnd);
            if (bus.last !== w_last) last_bad++;
            if (bus.cs == S_FIN && !seen_fin) begin
               seen_fin = 1; lat = cyc; fin_rnd = int'(bus.rnd);
            end
            if (bus.cs == S_IDLE) begin
               active = 0;
               if (!cur.abort) begin
                  chk("latency",    lat,            cur.lat);
                  chk("idle_edge",  cyc,            cur.lat + 1);
                  chk("fin_rnd",    fin_rnd,        cur.fin_rnd);
                  chk("n_last",     n_last,         cur.n_last);
                  chk("last_bad",   last_bad,       0);
                  chk("n_mix",      n_mix,          cur.n_mix);
                  chk("n_add",      n_add,          cur.n_add);
                  chk("first6",     int'(trace),    int'(cur.first6));
               end
            end
         end
         prev_cs = bus.cs;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic drive_dec(input logic d);
`ifdef AES_DEC_EN
      bus.dec = d;
`else
      if (d) $display("[TB] note: dec ignored in encrypt-only build");
`endif
   endtask

   task automatic wait_cond_idle(input string name);
      int k;
      k = 0;
      while (bus.cs != S_IDLE && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk({name, "_timeout"}, 1, 0);
   endtask

   task automatic run_block(input logic [1:0] kl, input logic d,
                            input bit stall, input bit fin_start);
      int k;
      wait_cond_idle("pre_start");
      bus.start = 1'b1; bus.key_len = kl; drive_dec(d);
      @(negedge clk);
      bus.start = 1'b0;
      if (stall) begin
         k = 0;
         while (!(bus.cs == S_SUB && bus.rnd == 4'd4) && k < 100) begin
            @(negedge clk); k++;
         end
         if (k >= 100) chk("stall_timeout", 1, 0);
         bus.en = 1'b0;
         bus.start = 1'b1; bus.key_len = 2'b11;   // must be ignored while busy
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_cs",  int'(bus.cs),  int'(S_SUB));
            chk("stall_rnd", int'(bus.rnd), 4);
         end
         bus.en = 1'b1; bus.start = 1'b0; bus.key_len = 2'b00;
      end
      k = 0;
      while (!bus.done && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk("done_timeout", 1, 0);
      if (fin_start) begin
         bus.start = 1'b1; bus.key_len = 2'b00;    // start in FIN is ignored
         @(negedge clk);
         bus.start = 1'b0;
      end else begin
         @(negedge clk);
      end
      wait_cond_idle("post_fin");
   endtask

   function automatic exp_t mk(input bit ab, input int lat, input int fr,
                               input int lr, input int nm, input int na,
                               input logic [17:0] f6);
      exp_t e;
      e.abort = ab; e.lat = lat; e.fin_rnd = fr; e.last_rnd = lr;
      e.n_last = 4; e.n_mix = nm; e.n_add = na; e.first6 = f6;
      return e;
   endfunction

   initial begin : stim
      int k;
      n_tests = 0; n_fail = 0; n_decode_bad = 0;
      res = 1'b0;
      bus.start = 1'b0; bus.key_len = 2'b00; bus.en = 1'b1;
      drive_dec(1'b0);
      repeat (3) @(negedge clk);
      chk("rst_cs",   int'(bus.cs),   0);
      chk("rst_rnd",  int'(bus.rnd),  0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_last", int'(bus.last), 0);
      chk("rst_err",  int'(bus.err),  0);
      res = 1'b1;
      @(negedge clk);

      // AES-128 / 192 / 256 encrypt
      sb_q.push_back(mk(0, 50, 10, 10,  9, 11, C_ENC6));
      run_block(2'b00, 1'b0, 0, 0);
      sb_q.push_back(mk(0, 60, 12, 12, 11, 13, C_ENC6));
      run_block(2'b01, 1'b0, 0, 0);
      sb_q.push_back(mk(0, 70, 14, 14, 13, 15, C_ENC6));
      run_block(2'b10, 1'b0, 0, 0);

      // Reserved key length: one err pulse, no block
      err_q.push_back(1);
      bus.start = 1'b1; bus.key_len = 2'b11;
      @(negedge clk);
      bus.start = 1'b0; bus.key_len = 2'b00;
      chk("err_busy", int'(bus.busy), 0);
      repeat (3) @(negedge clk);

      // Stall of 3 cycles in round-4 SUB, plus start pulses while busy
      sb_q.push_back(mk(0, 53, 10, 10, 9, 11, C_ENC6));
      run_block(2'b00, 1'b0, 1, 1);

      // Asynchronous reset during MIX of round 6
      sb_q.push_back(mk(1, 0, 0, 10, 0, 0, C_ENC6));
      bus.start = 1'b1; bus.key_len = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!(bus.cs == S_MIX && bus.rnd == 4'd6) && k < 100) begin
         @(negedge clk); k++;
      end
      if (k >= 100) chk("mix6_timeout", 1, 0);
      #2 res = 1'b0;
      #1;
      chk("arst_cs",   int'(bus.cs),   0);
      chk("arst_rnd",  int'(bus.rnd),  0);
      chk("arst_busy", int'(bus.busy), 0);
      @(negedge clk);
      #2 res = 1'b1;
      @(negedge clk);
      sb_q.push_back(mk(0, 50, 10, 10, 9, 11, C_ENC6));
      run_block(2'b00, 1'b0, 0, 0);

`ifdef AES_DEC_EN
      // Inverse cipher, AES-128
      sb_q.push_back(mk(0, 50, 0, 0, 9, 11, C_DEC6));
      run_block(2'b00, 1'b1, 0, 0);
      drive_dec(1'b0);
`endif

      repeat (4) @(negedge clk);
      chk("decode_bad",   n_decode_bad,  0);
      chk("sb_q_empty",   sb_q.size(),   0);
      chk("err_q_empty",  err_q.size(),  0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
